// File: rtl/puf_pkg.sv
// Shared types and constants for the arbiter-PUF challenge driver.
// Holds the FSM state encoding and the 8-bit Galois LFSR step rule.
package puf_pkg;

    localparam int CH_W = 8;
    localparam logic [CH_W-1:0] LFSR_TAPS         = 8'hB8;
    localparam logic [CH_W-1:0] LFSR_DEFAULT_SEED = 8'h01;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LAUNCH,
        SAMPLE,
        DONE
    } state_t;

    // Right-shifting Galois step; taps fold in when the bit shifted out is 1.
    function automatic logic [CH_W-1:0] lfsr_step(input logic [CH_W-1:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction

endpackage

// File: rtl/puf_lfsr.sv
// Challenge generator: 8-bit Galois LFSR, period 255.
// Latency: load/advance take effect on the next clock edge.
// Backpressure: none; the owner decides when to advance.
module puf_lfsr
    import puf_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [CH_W-1:0] seed,
    input  logic            advance,
    output logic [CH_W-1:0] value
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= LFSR_DEFAULT_SEED;
        end else if (load) begin
            value <= seed;
        end else if (advance) begin
            value <= lfsr_step(value);
        end
    end

endmodule

// File: rtl/puf_challenge_driver.sv
// Drives arbiter-PUF challenges and packs RESP_BITS responses into one word (PUF_MAJORITY_VOTE_EN adds voting).
// Latency: resp_valid rises RESP_BITS*passes*(SETUP_CYCLES+SETTLE_CYCLES+1) cycles after the accepted start.
// Backpressure: resp_word is held in DONE until resp_ready; start is ignored while busy.
module puf_challenge_driver
    import puf_pkg::*;
#(
    parameter int RESP_BITS     = 16,
    parameter int SETUP_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 16,
    parameter int VOTES         = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CH_W-1:0]      seed,
    output logic                 busy,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [RESP_BITS-1:0] resp_word,
    output logic [CH_W-1:0]      puf_ch,
    output logic                 puf_launch,
    output logic                 puf_arb_rst,
    input  logic                 puf_resp,
    output logic [7:0]           unstable_cnt
);

`ifdef PUF_MAJORITY_VOTE_EN
    localparam int PASSES = VOTES;
`else
    localparam int PASSES = 1;
`endif
    localparam int TMAX = (SETUP_CYCLES > SETTLE_CYCLES) ? SETUP_CYCLES : SETTLE_CYCLES;
    localparam int CW   = $clog2(TMAX + 1);
    localparam int IW   = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam int VW   = $clog2(PASSES + 1);

    if (RESP_BITS < 1 || RESP_BITS > 32 || SETUP_CYCLES < 1 || SETTLE_CYCLES < 3 ||
        VOTES < 1 || (VOTES % 2) == 0) begin : g_bad_params
        $error("puf_challenge_driver: illegal parameter set");
    end

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   idx;
    logic [VW-1:0]   vote, ones, ones_tot;
    logic [1:0]      sync;
    logic [CH_W-1:0] lfsr_val, seed_eff;
    logic            resp_s, last_pass, last_bit, eval_bit;
    logic            setup_done, settle_done, lfsr_load, lfsr_adv;

    assign seed_eff    = (seed == '0) ? LFSR_DEFAULT_SEED : seed;
    assign resp_s      = sync[1];
    assign ones_tot    = ones + VW'(resp_s);
    assign last_pass   = (vote == VW'(PASSES - 1));
    assign eval_bit    = (ones_tot > VW'(PASSES / 2));
    assign last_bit    = (idx == IW'(RESP_BITS - 1));
    assign setup_done  = (cnt == CW'(SETUP_CYCLES - 1));
    assign settle_done = (cnt == CW'(SETTLE_CYCLES - 1));

    puf_lfsr u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (lfsr_load),
        .seed    (seed_eff),
        .advance (lfsr_adv),
        .value   (lfsr_val)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        busy        = 1'b1;
        resp_valid  = 1'b0;
        puf_launch  = 1'b0;
        puf_arb_rst = 1'b1;
        lfsr_load   = 1'b0;
        lfsr_adv    = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    lfsr_load = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                if (setup_done) state_nxt = LAUNCH;
            end
            LAUNCH: begin
                puf_arb_rst = 1'b0;
                puf_launch  = 1'b1;
                if (settle_done) state_nxt = SAMPLE;
            end
            SAMPLE: begin
                // Arbiter stays out of reset so its latched decision is still visible.
                puf_arb_rst = 1'b0;
                lfsr_adv    = last_pass;
                state_nxt   = (last_pass && last_bit) ? DONE : SETUP;
            end
            DONE: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync      <= '0;
            cnt       <= '0;
            idx       <= '0;
            vote      <= '0;
            ones      <= '0;
            resp_word <= '0;
            puf_ch    <= '0;
        end else begin
            sync <= {sync[0], puf_resp};
            cnt  <= (state_nxt == state) ? cnt + CW'(1) : '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        idx       <= '0;
                        vote      <= '0;
                        ones      <= '0;
                        resp_word <= '0;
                        puf_ch    <= seed_eff;
                    end
                end
                SAMPLE: begin
                    if (last_pass) begin
                        resp_word <= resp_word | (RESP_BITS'(eval_bit) << idx);
                        vote      <= '0;
                        ones      <= '0;
                        // puf_ch tracks the LFSR only when a new challenge is about to be set up.
                        if (!last_bit) begin
                            idx    <= idx + IW'(1);
                            puf_ch <= lfsr_step(lfsr_val);
                        end
                    end else begin
                        vote <= vote + VW'(1);
                        ones <= ones_tot;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PUF_MAJORITY_VOTE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            unstable_cnt <= '0;
        end else if (state == IDLE && start) begin
            unstable_cnt <= '0;
        end else if (state == SAMPLE && last_pass && ones_tot != '0 &&
                     ones_tot != VW'(PASSES) && unstable_cnt != 8'hFF) begin
            unstable_cnt <= unstable_cnt + 8'd1;
        end
    end
`else
    assign unstable_cnt = '0;
`endif

endmodule

// File: tb/tb_puf_challenge_driver.sv
// Bench for puf_challenge_driver: a behavioural arbiter model drives puf_resp from puf_ch,
// expected words come from walking the challenge sequence with plain arithmetic.
module tb_puf_challenge_driver;

    localparam int RB = 16;
    localparam int SU = 4;
    localparam int ST = 16;
    localparam int NV = 5;
`ifdef PUF_MAJORITY_VOTE_EN
    localparam int PASSES = NV;
`else
    localparam int PASSES = 1;
`endif
    localparam int T_BIT = PASSES * (SU + ST + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          resp_ready = 1'b0;
    logic [7:0]    seed = 8'h00;
    logic          puf_resp;
    logic          busy, resp_valid, puf_launch, puf_arb_rst;
    logic [RB-1:0] resp_word;
    logic [7:0]    puf_ch, unstable_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    // Arbiter model: 0 = always 1, 1 = ch[0], 2 = random table per challenge, 3 = scripted votes
    int         mode = 0;
    bit         resp_tab [256];
    int         launch_base = 0;
    logic [4:0] vote_pat = 5'b01011;

    logic [7:0] ch_log [$];
    int         launch_cnt = 0;
    int         stab_viol = 0;
    int         valid_seen = 0;
    logic       launch_prev = 1'b0;
    logic [7:0] ch_prev = 8'h00;

    always #5 clk = ~clk;

    puf_challenge_driver #(
        .RESP_BITS     (RB),
        .SETUP_CYCLES  (SU),
        .SETTLE_CYCLES (ST),
        .VOTES         (NV)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .seed         (seed),
        .busy         (busy),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_word    (resp_word),
        .puf_ch       (puf_ch),
        .puf_launch   (puf_launch),
        .puf_arb_rst  (puf_arb_rst),
        .puf_resp     (puf_resp),
        .unstable_cnt (unstable_cnt)
    );

    always @(posedge clk) begin
        if (puf_launch && !launch_prev) begin
            ch_log.push_back(puf_ch);
            launch_cnt++;
        end
        if (puf_launch && launch_prev && puf_ch !== ch_prev) stab_viol++;
        if (resp_valid === 1'b1) valid_seen++;
        launch_prev = puf_launch;
        ch_prev     = puf_ch;
    end

    always_comb begin
        case (mode)
            0:       puf_resp = 1'b1;
            1:       puf_resp = puf_ch[0];
            2:       puf_resp = resp_tab[puf_ch];
            default: begin
                puf_resp = 1'b1;
                if (launch_cnt - launch_base >= 1 && launch_cnt - launch_base <= 5)
                    puf_resp = vote_pat[launch_cnt - launch_base - 1];
            end
        endcase
    end

    function automatic logic [7:0] m_next(input logic [7:0] v);
        return (v % 2 == 1) ? ((v / 2) ^ 8'hB8) : (v / 2);
    endfunction

    function automatic bit m_resp(input logic [7:0] ch);
        case (mode)
            0:       return 1'b1;
            1:       return ch[0];
            2:       return resp_tab[ch];
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [RB-1:0] m_word(input logic [7:0] sd);
        logic [7:0]    v = (sd == 8'h00) ? 8'h01 : sd;
        logic [RB-1:0] w = '0;
        for (int i = 0; i < RB; i++) begin
            w[i] = m_resp(v);
            v    = m_next(v);
        end
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic run(input logic [7:0] sd, output int lat, output int base);
        base = ch_log.size();
        @(negedge clk);
        seed  = sd;
        start = 1'b1;
        @(posedge clk);
        #1;
        lat = 0;
        @(negedge clk);
        start = 1'b0;
        while (resp_valid !== 1'b1 && lat < 4000) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic chk_seq(input string tag, input logic [7:0] sd, input int base);
        logic [7:0] v = (sd == 8'h00) ? 8'h01 : sd;
        int bad = 0;
        if (ch_log.size() < base + RB * PASSES) begin
            bad = 1000;
        end else begin
            for (int i = 0; i < RB; i++) begin
                for (int p = 0; p < PASSES; p++)
                    if (ch_log[base + i * PASSES + p] !== v) bad++;
                v = m_next(v);
            end
        end
        chk(tag, bad, 0);
    endtask

    task automatic accept();
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("busy_after_handshake", {31'd0, busy}, 0);
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, base, sv0, vs0, bad, w;
        logic [7:0]  sd;
        logic [31:0] f4;
        logic [RB-1:0] w0;

        for (int i = 0; i < 256; i++) resp_tab[i] = 1'($urandom_range(0, 1));

        // Reset values
        #1;
        chk("rst_busy",        {31'd0, busy}, 0);
        chk("rst_resp_valid",  {31'd0, resp_valid}, 0);
        chk("rst_resp_word",   32'(resp_word), 0);
        chk("rst_puf_ch",      {24'd0, puf_ch}, 0);
        chk("rst_puf_launch",  {31'd0, puf_launch}, 0);
        chk("rst_puf_arb_rst", {31'd0, puf_arb_rst}, 1);
        chk("rst_unstable",    {24'd0, unstable_cnt}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Response tied high, seed 01
        mode = 0;
        sv0  = stab_viol;
        launch_base = launch_cnt;
        run(8'h01, lat, base);
        chk("tie1_latency", lat, RB * T_BIT);
        chk("tie1_word_const", 32'(resp_word), 32'h0000FFFF);
        chk("tie1_word_model", 32'(resp_word), 32'(m_word(8'h01)));
        f4 = '0;
        for (int k = 0; k < 4; k++)
            if (base + k * PASSES < ch_log.size()) f4 = {f4[23:0], ch_log[base + k * PASSES]};
        chk("tie1_ch_first4", f4, 32'h01B85C2E);
        chk_seq("tie1_ch_seq", 8'h01, base);
        chk("tie1_ch_stable", stab_viol - sv0, 0);
        chk("tie1_unstable", {24'd0, unstable_cnt}, 0);
        accept();

        // Response = ch[0]
        mode = 1;
        run(8'h01, lat, base);
        chk("ch0_word_low4", {28'd0, resp_word[3:0]}, 32'h1);
        chk("ch0_word_model", 32'(resp_word), 32'(m_word(8'h01)));
        accept();

        // Zero seed is replaced by 01
        mode = 2;
        sv0  = stab_viol;
        run(8'h00, lat, base);
        chk("seed0_first_ch", (ch_log.size() > base) ? {24'd0, ch_log[base]} : 32'hFFFF_FFFF, 32'h01);
        chk("seed0_word_model", 32'(resp_word), 32'(m_word(8'h00)));
        chk_seq("seed0_ch_seq", 8'h00, base);
        accept();

        // Random seeds against the random response table
        for (int r = 0; r < 3; r++) begin
            sd = 8'($urandom);
            run(sd, lat, base);
            chk("rand_latency", lat, RB * T_BIT);
            chk("rand_word_model", 32'(resp_word), 32'(m_word(sd)));
            chk_seq("rand_ch_seq", sd, base);
            accept();
        end
        chk("all_ch_stable", stab_viol - sv0, 0);

        // Backpressure: hold resp_ready low, pulse start
        mode = 1;
        run(8'h5A, lat, base);
        w0 = resp_word;
        chk("bp_word_model", 32'(w0), 32'(m_word(8'h5A)));
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            start = (c == 10);
            @(posedge clk);
            #1;
            if (resp_valid !== 1'b1 || resp_word !== w0) bad++;
        end
        @(negedge clk);
        start = 1'b0;
        chk("bp_hold_stable", bad, 0);
        chk("bp_busy_held", {31'd0, busy}, 1);
        resp_ready = 1'b1;
        start      = 1'b1;
        @(posedge clk);
        #1;
        chk("hs_busy_low", {31'd0, busy}, 0);
        chk("hs_valid_low", {31'd0, resp_valid}, 0);
        @(negedge clk);
        start      = 1'b0;
        resp_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("hs_start_ignored", {31'd0, busy}, 0);

        // Reset in the middle of LAUNCH aborts the run
        mode = 0;
        vs0  = valid_seen;
        @(negedge clk);
        seed  = 8'h01;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (puf_launch !== 1'b1 && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("abort_reached_launch", {31'd0, puf_launch}, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_arb_rst", {31'd0, puf_arb_rst}, 1);
        chk("abort_launch", {31'd0, puf_launch}, 0);
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_puf_ch", {24'd0, puf_ch}, 0);
        chk("abort_resp_word", 32'(resp_word), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (400) @(posedge clk);
        #1;
        chk("abort_no_valid", valid_seen - vs0, 0);

`ifdef PUF_MAJORITY_VOTE_EN
        // Bit-0 votes 1,1,0,1,0 then all remaining evaluations 1
        mode = 3;
        launch_base = launch_cnt;
        run(8'h01, lat, base);
        chk("vote_latency", lat, 1680);
        chk("vote_bit0", {31'd0, resp_word[0]}, 1);
        chk("vote_word", 32'(resp_word), 32'h0000FFFF);
        chk("vote_unstable", {24'd0, unstable_cnt}, 1);
        chk_seq("vote_ch_seq", 8'h01, base);
        accept();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
